// File: rtl/pc_fetch.sv
// pc_fetch: architectural PC holder and single-outstanding instruction fetcher.
// Issues one imem request per retirement, buffers the returned word for decode
// with valid/ready flow control, and handles flush redirects, misaligned PCs and
// ack timeouts. All outputs come straight from flops.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        fetch_err,
  output logic [31:0] fetch_count
);

  // Wide enough to hold the value TIMEOUT itself.
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    StFetch,
    StHold,
    StDrain,
    StErr
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            req_q, req_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [TmoW-1:0] tmo_inc;
  logic            tmo_expire;

  // Timeout expires on the cycle whose miss would bring the count to TIMEOUT.
  assign tmo_inc    = tmo_q + TmoW'(1);
  assign tmo_expire = (tmo_inc == TmoW'(TIMEOUT));

  // Next-state logic: flush takes priority over every state-local event.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;

    if (flush) begin
      // Any ack arriving with the flush belongs to the old stream and is dropped.
      pc_d    = flush_pc;
      valid_d = 1'b0;
      tmo_d   = '0;
      if (flush_pc[1:0] != 2'b00) begin
        err_d   = 1'b1;
        state_d = StErr;
      end else begin
        err_d   = 1'b0;
        // A request still in flight must be drained before re-issuing.
        state_d = (state_q == StFetch && !imem_ack) ? StDrain : StFetch;
      end
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem_ack) begin
            instr_d = imem_rdata;
            valid_d = 1'b1;
            tmo_d   = '0;
            state_d = StHold;
          end else if (tmo_expire) begin
            err_d   = 1'b1;
            tmo_d   = '0;
            state_d = StErr;
          end else begin
            tmo_d = tmo_inc;
          end
        end
        StHold: begin
          if (instr_ready) begin
            pc_d    = npc;
            valid_d = 1'b0;
            cnt_d   = cnt_q + 32'd1;
            tmo_d   = '0;
            if (npc[1:0] != 2'b00) begin
              err_d   = 1'b1;
              state_d = StErr;
            end else begin
              state_d = StFetch;
            end
          end
        end
        StDrain: begin
          // Stale data is discarded; a lost ack must not wedge the fetcher.
          if (imem_ack || tmo_expire) begin
            tmo_d   = '0;
            state_d = StFetch;
          end else begin
            tmo_d = tmo_inc;
          end
        end
        StErr: begin
          valid_d = 1'b0;
        end
        default: begin
          state_d = StFetch;
        end
      endcase
    end

    req_d = (state_d == StFetch);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      req_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      req_q   <= req_d;
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = req_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fetch_err   = err_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed stimulus, a behavioural reference model compared
// every cycle, and literal expectations at key points of each scenario.
module tb_pc_fetch;

  localparam int unsigned Timeout = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] npc = '0;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        fetch_err;
  logic [31:0] fetch_count;

  int checks = 0;
  int failures = 0;

  // Tells the model the DUT counter was forced to all-ones before this edge.
  logic cnt_load = 1'b0;

  pc_fetch #(
    .RESET_PC(32'h0000_3000),
    .TIMEOUT (Timeout)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .npc        (npc),
    .pc         (pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .fetch_err  (fetch_err),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. Modes: 0 waiting on memory, 1 holding an instruction,
  // 2 discarding a stale response, 3 stopped on error.
  int          m_mode = 0;
  int          m_miss = 0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_cnt = '0;
  logic        m_valid = 1'b0;
  logic        m_err = 1'b0;
  logic        m_init = 1'b0;

  always @(posedge clk) begin : model_p
    int          mode;
    int          miss;
    logic [31:0] p;
    logic [31:0] ins;
    logic [31:0] cnt;
    logic        v;
    logic        e;
    mode = m_mode; miss = m_miss; p = m_pc; ins = m_instr; v = m_valid; e = m_err;
    cnt = cnt_load ? 32'hFFFF_FFFF : m_cnt;
    if (rst) begin
      mode = 0; miss = 0; p = 32'h0000_3000; ins = 0; v = 0; e = 0; cnt = 0;
    end else if (flush) begin
      p = flush_pc; v = 0; miss = 0;
      if (flush_pc % 4 != 0) begin e = 1; mode = 3; end
      else begin
        e = 0;
        mode = (mode == 0 && !imem_ack) ? 2 : 0;
      end
    end else if (mode == 0) begin
      if (imem_ack) begin ins = imem_rdata; v = 1; miss = 0; mode = 1; end
      else begin
        miss++;
        if (miss == Timeout) begin e = 1; miss = 0; mode = 3; end
      end
    end else if (mode == 1) begin
      if (instr_ready) begin
        p = npc; v = 0; cnt = cnt + 1; miss = 0;
        if (npc % 4 != 0) begin e = 1; mode = 3; end else mode = 0;
      end
    end else if (mode == 2) begin
      miss++;
      if (imem_ack || miss == Timeout) begin miss = 0; mode = 0; end
    end
    m_mode <= mode; m_miss <= miss; m_pc <= p; m_instr <= ins;
    m_valid <= v; m_err <= e; m_cnt <= cnt;
    if (rst) m_init <= 1'b1;
  end

  // Compare every output against the model once it has seen a reset.
  always @(negedge clk) begin
    if (m_init) begin
      cmp("pc", pc, m_pc);
      cmp("imem_addr", imem_addr, m_pc);
      cmp("imem_req", {31'd0, imem_req}, {31'd0, m_mode == 0});
      cmp("instr", instr, m_instr);
      cmp("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
      cmp("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
      cmp("fetch_count", fetch_count, m_cnt);
    end
  end

  // One clock: inputs already applied; returns just after the following negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Watchdog so the run always ends.
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset
    step();
    cmp("rst pc", pc, 32'h0000_3000);
    cmp("rst req", {31'd0, imem_req}, 32'd1);
    cmp("rst valid", {31'd0, instr_valid}, 32'd0);
    cmp("rst count", fetch_count, 32'd0);

    // 1: ack on the first request cycle, then retire
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    step();
    cmp("t1 valid", {31'd0, instr_valid}, 32'd1);
    cmp("t1 instr", instr, 32'h2008_0005);
    cmp("t1 pc", pc, 32'h0000_3000);
    imem_ack = 1'b0; instr_ready = 1'b1; npc = 32'h0000_3004;
    step();
    cmp("t1 addr", imem_addr, 32'h0000_3004);
    cmp("t1 count", fetch_count, 32'd1);
    cmp("t1 req", {31'd0, imem_req}, 32'd1);
    instr_ready = 1'b0;

    // 2: ack delayed three cycles, then a full timeout
    for (int i = 0; i < 3; i++) begin
      step();
      cmp("t2 wait addr", imem_addr, 32'h0000_3004);
      cmp("t2 wait req", {31'd0, imem_req}, 32'd1);
    end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    step();
    cmp("t2 valid", {31'd0, instr_valid}, 32'd1);
    cmp("t2 no err", {31'd0, fetch_err}, 32'd0);
    imem_ack = 1'b0; instr_ready = 1'b1; npc = 32'h0000_3008;
    step();
    instr_ready = 1'b0;
    for (int i = 0; i < int'(Timeout) - 1; i++) begin
      step();
      cmp("t2 req before timeout", {31'd0, imem_req}, 32'd1);
    end
    step();
    cmp("t2 timeout err", {31'd0, fetch_err}, 32'd1);
    cmp("t2 timeout req", {31'd0, imem_req}, 32'd0);

    // 3: misaligned npc from HOLD, then recover with a flush
    flush = 1'b1; flush_pc = 32'h0000_3100;
    step();
    flush = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
    step();
    imem_ack = 1'b0; instr_ready = 1'b1; npc = 32'h0000_3002;
    step();
    instr_ready = 1'b0;
    cmp("t3 err", {31'd0, fetch_err}, 32'd1);
    cmp("t3 count", fetch_count, 32'd3);
    step();
    step();
    cmp("t3 req stays low", {31'd0, imem_req}, 32'd0);
    flush = 1'b1; flush_pc = 32'h0000_4000;
    step();
    flush = 1'b0;
    cmp("t3 err cleared", {31'd0, fetch_err}, 32'd0);
    cmp("t3 addr", imem_addr, 32'h0000_4000);
    cmp("t3 req", {31'd0, imem_req}, 32'd1);

    // 4: flush with a request in flight; late ack is discarded
    flush = 1'b1; flush_pc = 32'h0000_5000;
    step();
    flush = 1'b0;
    cmp("t4 drain req", {31'd0, imem_req}, 32'd0);
    step();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    cmp("t4 valid", {31'd0, instr_valid}, 32'd0);
    cmp("t4 instr kept", instr, 32'h0000_0033);
    cmp("t4 addr", imem_addr, 32'h0000_5000);
    cmp("t4 req", {31'd0, imem_req}, 32'd1);

    // 5a: flush together with instr_ready
    imem_ack = 1'b1; imem_rdata = 32'h0000_0093;
    step();
    imem_ack = 1'b0; instr_ready = 1'b1; npc = 32'h0000_5004;
    flush = 1'b1; flush_pc = 32'h0000_6000;
    step();
    instr_ready = 1'b0; flush = 1'b0;
    cmp("t5 pc", pc, 32'h0000_6000);
    cmp("t5 count", fetch_count, 32'd3);
    cmp("t5 valid", {31'd0, instr_valid}, 32'd0);
    // 5b: flush together with imem_ack
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0001; flush = 1'b1; flush_pc = 32'h0000_7000;
    step();
    imem_ack = 1'b0; flush = 1'b0;
    cmp("t5 ack pc", pc, 32'h0000_7000);
    cmp("t5 ack valid", {31'd0, instr_valid}, 32'd0);
    cmp("t5 ack req", {31'd0, imem_req}, 32'd1);
    step();
    cmp("t5 ack still invalid", {31'd0, instr_valid}, 32'd0);

    // 6: fetch counter wrap, then reset mid-fetch
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    step();
    imem_ack = 1'b0;
    force dut.cnt_q = 32'hFFFF_FFFF;
    cnt_load = 1'b1;
    #1;
    release dut.cnt_q;
    instr_ready = 1'b1; npc = 32'h0000_7004;
    step();
    instr_ready = 1'b0; cnt_load = 1'b0;
    cmp("t6 wrap", fetch_count, 32'd0);
    cmp("t6 pc", pc, 32'h0000_7004);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0; instr_ready = 1'b1; npc = 32'h0000_7008;
    step();
    instr_ready = 1'b0;
    step();
    rst = 1'b1; flush = 1'b1; flush_pc = 32'h0000_8000;
    step();
    rst = 1'b0; flush = 1'b0;
    cmp("t6 rst pc", pc, 32'h0000_3000);
    cmp("t6 rst req", {31'd0, imem_req}, 32'd1);
    cmp("t6 rst instr", instr, 32'd0);
    cmp("t6 rst count", fetch_count, 32'd0);
    cmp("t6 rst err", {31'd0, fetch_err}, 32'd0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Holds the architectural PC and fetches one instruction per retirement from instruction memory over a req/ack handshake.
- Consumes the next-PC value produced by the next-PC logic and returns the current PC to it for PC+4, branch and jump computation.
- Buffers the fetched instruction in a one-entry output register for decode, with valid/ready flow control.
- Supports flush redirect, an alignment check, an ack timeout and a fetch counter.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.
TIMEOUT, 16, cycles to wait for imem_ack before raising fetch_err; minimum 2.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
npc  input  32  next PC from the next-PC logic, valid while instr_valid=1.
pc  output  32  current PC, to the next-PC logic and to decode.
imem_req  output  1  instruction memory request.
imem_addr  output  32  request address; always equals pc.
imem_ack  input  1  one-cycle pulse: rdata valid, request complete.
imem_rdata  input  32  instruction word.
instr  output  32  fetched instruction.
instr_valid  output  1  instr holds a valid instruction for pc.
instr_ready  input  1  decode/execute retires instr this cycle.
flush  input  1  redirect to flush_pc; overrides everything except rst.
flush_pc  input  32  redirect target.
fetch_err  output  1  misaligned PC or ack timeout; sticky.
fetch_count  output  32  number of retired instructions; wraps at 2^32.

Behaviour:
- Reset (rst=1 at clk edge): pc=RESET_PC, state=FETCH, instr=0, instr_valid=0, fetch_err=0, fetch_count=0, timeout counter=0. imem_req=1 the first cycle after reset.
- States: FETCH, HOLD, DRAIN, ERR. imem_req=1 only in FETCH. imem_req, imem_addr and pc are registered outputs.
- FETCH, address stable:
  - imem_req held, address stable until imem_ack.
  - On ack: instr<=imem_rdata, instr_valid<=1, go HOLD. Minimum latency is 1 cycle from req to instr_valid.
  - Each cycle without ack increments the timeout counter. When it reaches TIMEOUT: fetch_err<=1, go ERR.
- HOLD:
  - When instr_ready=1: pc<=npc, instr_valid<=0, fetch_count+=1, timeout counter cleared, go FETCH.
  - If npc[1:0]!=0: pc<=npc, fetch_err<=1, go ERR instead; fetch_count still increments.
  - instr_ready while instr_valid=0 is ignored.
- DRAIN:
  - imem_req=0; wait for the outstanding imem_ack and discard its data, then go FETCH.
  - The timeout counter also runs here; on expiry go FETCH.
- ERR: imem_req=0, instr_valid=0; held until flush or rst.
- Flush, from any state:
  - pc<=flush_pc, instr_valid<=0, fetch_err<=0, timeout counter cleared.
  - Next state is DRAIN if in FETCH with no ack this cycle; otherwise FETCH.
  - An ack coincident with flush is discarded.
  - A flush_pc with bits [1:0]!=0 sets fetch_err and goes ERR.
- Simultaneous flush and instr_ready: flush wins and fetch_count is not incremented.
- rst overrides flush and every other event.

Test Plan:
1. Reset, ack on the first req cycle with rdata=32'h2008_0005 -> pc=32'h0000_3000, instr_valid=1 next cycle. Then instr_ready with npc=32'h0000_3004 -> imem_addr=32'h0000_3004, fetch_count=1.
2. Ack delayed 3 cycles, TIMEOUT=16 -> imem_req held 3 cycles with a stable address, no fetch_err. Then no ack for 16 cycles -> fetch_err=1, state ERR, imem_req=0.
3. In HOLD, npc=32'h0000_3002 with instr_ready -> fetch_err=1, imem_req stays 0. Then flush_pc=32'h0000_4000 -> fetch_err=0, fetch from 32'h0000_4000.
4. Flush to 32'h0000_5000 during FETCH with no ack; ack arrives 2 cycles later with rdata=32'hDEAD_BEEF -> data discarded, instr_valid stays 0. Next req goes to 32'h0000_5000.
5. Same-cycle flush + instr_ready, and same-cycle flush + imem_ack -> pc=flush_pc, fetch_count unchanged, no stale instr_valid.
6. Retire 2^32 instructions (force fetch_count=32'hFFFF_FFFF) -> wraps to 0. rst asserted mid-FETCH -> all outputs take their reset values next cycle.
